noc_common_clk_gate_ctrl: RTL and testbench
===========================================

Name: noc_common_clk_gate_ctrl

Overview:
- Idle-detect and wake controller that drives the EN pin of the NoC unit clock gater; it sits directly upstream of that gater, in the free-running clock domain.
- Counts consecutive idle cycles of the NoC unit and drops the enable after a programmable threshold.
- Re-enables the clock on pending traffic or a force request, then runs a req/ack wake handshake so requestors only transfer once the gated clock is stable.

Parameters:
- CntW, 8: width of the idle counter and of the threshold input.
- WakeCycles, 2: cycles from o_clk_en rising to o_wake_ack (gater latch plus clock-tree settle). Legal range 1..15.

Ports:
- i_clk  in  1  free-running clock (ungated side of the gater)
- i_rst_n  in  1  asynchronous active-low reset
- i_cfg_idle_thresh  in  CntW  idle cycles before gating; 0 = gating disabled
- i_force_on  in  1  keep clock enabled (SW/debug override)
- i_busy  in  1  unit has outstanding work; must be generated from ungated logic
- i_wake_req  in  1  requestor has a transfer pending; held until o_wake_ack
- o_wake_ack  out  1  clock running and stable, transfer may proceed
- o_clk_en  out  1  to gater EN
- o_gated  out  1  status: clock currently gated

Behaviour:
- Reset values: state RUN, o_clk_en=1, o_gated=0, o_wake_ack=0, counters 0. The clock is on out of reset.
- All outputs are registered, except o_wake_ack = (state==RUN) & i_wake_req.
- active = i_busy | i_wake_req | i_force_on | (i_cfg_idle_thresh==0).
- States: RUN, GATED, WAKE.
- RUN:
  - o_clk_en=1.
  - idle_cnt clears to 0 on any active cycle and increments otherwise.
  - If !active and idle_cnt+1 >= i_cfg_idle_thresh, go to GATED. o_clk_en=0 and o_gated=1 from the next cycle, i.e. after exactly thresh consecutive idle cycles.
  - The >= compare means that lowering the threshold mid-count gates on the next idle cycle.
  - idle_cnt saturates at all-ones and never wraps.
- GATED:
  - o_clk_en=0.
  - Any active condition moves to WAKE. o_clk_en=1 and o_gated=0 from the next cycle; wake_cnt loads 0.
- WAKE:
  - o_clk_en=1, wake_cnt increments.
  - When wake_cnt==WakeCycles-1, go to RUN with idle_cnt=0.
  - WAKE always completes, even if i_wake_req drops.
- Wake latency: i_wake_req rising in GATED at cycle N gives o_clk_en=1 at N+1 and o_wake_ack at N+1+WakeCycles. In RUN, ack is same-cycle.
- Simultaneous events: activity on the cycle gating would occur cancels gating (stay in RUN, idle_cnt=0). Force-on in any state means never entering or remaining in GATED.
- Threshold 0 while GATED is treated as active, so the block wakes and stays on.
- Reset mid-operation (any state): o_clk_en goes high asynchronously and the block returns to RUN.
- o_clk_en toggles only on i_clk rising edges, so it is glitch-free into the gater latch.
- Scan is not handled here; the gater TE input covers it.

Optional Feature:
- Macro: NOC_CLK_GATE_STATS_EN.
- With the macro:
  - Adds outputs o_gated_cycles (32) and o_gate_events (16), both saturating and reset to 0.
  - o_gated_cycles increments each cycle state==GATED.
  - o_gate_events increments on each RUN->GATED transition.
- Without the macro: the ports and counters are absent and the rest of the behaviour is identical.

Test Plan:
- Reset with thresh=4, all inputs 0 -> o_clk_en=1 during/after reset; falls exactly 4 cycles after reset release; o_gated=1.
- thresh=4, i_busy pulse on the 4th idle cycle -> no gating; o_clk_en falls 4 cycles after the busy pulse.
- GATED, WakeCycles=2, i_wake_req asserted at cycle 10 -> o_clk_en=1 at 11, o_wake_ack=1 at 13, ack drops when req drops.
- thresh=0 or i_force_on=1 for 1000 cycles with zero activity -> o_clk_en stays 1; asserting force while GATED wakes in 1 cycle.
- i_rst_n asserted asynchronously while in GATED and in WAKE -> o_clk_en=1 immediately, no ack until RUN; regates after thresh idle cycles.
- NOC_CLK_GATE_STATS_EN: 3 gate periods of 20, 5, 7 cycles -> o_gate_events=3, o_gated_cycles=32; counters saturate at max and do not wrap.

Source files
------------

// File: rtl/noc_common_clk_gate_ctrl.sv
// Idle-detect / wake controller driving the EN pin of the NoC unit clock gater.
// Optional activity statistics are enabled with the NOC_CLK_GATE_STATS_EN macro.
module noc_common_clk_gate_ctrl #(
    parameter int CntW       = 8,
    parameter int WakeCycles = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [CntW-1:0] i_cfg_idle_thresh,
    input  logic            i_force_on,
    input  logic            i_busy,
    input  logic            i_wake_req,
    output logic            o_wake_ack,
    output logic            o_clk_en,
    output logic            o_gated
`ifdef NOC_CLK_GATE_STATS_EN
    ,
    output logic [31:0]     o_gated_cycles,
    output logic [15:0]     o_gate_events
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_GATED = 2'd1,
        ST_WAKE  = 2'd2
    } state_t;

    localparam logic [3:0]      WakeLast = 4'(WakeCycles - 1);
    localparam logic [CntW-1:0] CntMax   = '1;
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CntW-1:0] r_idle_cnt;
    logic [CntW-1:0] w_idle_cnt_nxt;
    logic [3:0]      r_wake_cnt;
    logic [3:0]      w_wake_cnt_nxt;
    logic            r_clk_en;
    logic            r_gated;
    logic            w_clk_en_nxt;
    logic            w_gated_nxt;
    logic            w_active;
    logic [CntW:0]   w_idle_inc;
    logic            w_thresh_hit;

    // A zero threshold counts as activity, so gating is disabled and a gated unit wakes.
    assign w_active     = i_busy | i_wake_req | i_force_on | (i_cfg_idle_thresh == '0);
    assign w_idle_inc   = {1'b0, r_idle_cnt} + {{CntW{1'b0}}, 1'b1};
    assign w_thresh_hit = (w_idle_inc >= {1'b0, i_cfg_idle_thresh});

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_RUN;
            r_idle_cnt <= '0;
            r_wake_cnt <= '0;
            r_clk_en   <= 1'b1;
            r_gated    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idle_cnt <= w_idle_cnt_nxt;
            r_wake_cnt <= w_wake_cnt_nxt;
            r_clk_en   <= w_clk_en_nxt;
            r_gated    <= w_gated_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_idle_cnt_nxt = r_idle_cnt;
        w_wake_cnt_nxt = r_wake_cnt;
        unique case (r_state)
            ST_RUN: begin
                if (w_active) begin
                    w_idle_cnt_nxt = '0;
                end else if (w_thresh_hit) begin
                    w_state_nxt    = ST_GATED;
                    w_idle_cnt_nxt = '0;
                end else if (r_idle_cnt != CntMax) begin
                    w_idle_cnt_nxt = r_idle_cnt + CntOne;
                end
            end
            ST_GATED: begin
                if (w_active) begin
                    w_state_nxt    = ST_WAKE;
                    w_wake_cnt_nxt = '0;
                end
            end
            ST_WAKE: begin
                // Wake runs to completion so the tree settles even if the request is withdrawn.
                if (r_wake_cnt == WakeLast) begin
                    w_state_nxt    = ST_RUN;
                    w_idle_cnt_nxt = '0;
                end else begin
                    w_wake_cnt_nxt = r_wake_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt    = ST_RUN;
                w_idle_cnt_nxt = '0;
                w_wake_cnt_nxt = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so EN only moves on i_clk edges.
    always_comb begin
        w_clk_en_nxt = (w_state_nxt != ST_GATED);
        w_gated_nxt  = (w_state_nxt == ST_GATED);
    end

    assign o_clk_en   = r_clk_en;
    assign o_gated    = r_gated;
    assign o_wake_ack = (r_state == ST_RUN) & i_wake_req;

`ifdef NOC_CLK_GATE_STATS_EN
    logic [31:0] r_gated_cycles;
    logic [15:0] r_gate_events;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gated_cycles <= '0;
            r_gate_events  <= '0;
        end else begin
            if ((r_state == ST_GATED) && (r_gated_cycles != 32'hFFFF_FFFF)) begin
                r_gated_cycles <= r_gated_cycles + 32'd1;
            end
            if ((r_state == ST_RUN) && (w_state_nxt == ST_GATED) && (r_gate_events != 16'hFFFF)) begin
                r_gate_events <= r_gate_events + 16'd1;
            end
        end
    end

    assign o_gated_cycles = r_gated_cycles;
    assign o_gate_events  = r_gate_events;
`endif

endmodule

// File: tb/tb_noc_common_clk_gate_ctrl.sv
// Scoreboard bench for noc_common_clk_gate_ctrl: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_noc_common_clk_gate_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] thresh;
    logic       force_on;
    logic       busy;
    logic       wake_req;
    logic       wake_ack;
    logic       clk_en;
    logic       gated;
`ifdef NOC_CLK_GATE_STATS_EN
    logic [31:0] gated_cycles;
    logic [15:0] gate_events;
`endif

    noc_common_clk_gate_ctrl #(.CntW(8), .WakeCycles(2)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_cfg_idle_thresh (thresh),
        .i_force_on        (force_on),
        .i_busy            (busy),
        .i_wake_req        (wake_req),
        .o_wake_ack        (wake_ack),
        .o_clk_en          (clk_en),
        .o_gated           (gated)
`ifdef NOC_CLK_GATE_STATS_EN
        ,
        .o_gated_cycles    (gated_cycles),
        .o_gate_events     (gate_events)
`endif
    );

    typedef struct {
        int          cyc;
        logic        en;
        logic        g;
        logic        ack;
        bit          st;
        logic [31:0] gc;
        logic [15:0] ge;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, time %0t required end before 500000", $time);
        $fatal(1, "watchdog");
    end

    // Monitor: pops every expectation stamped with the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            n_tests++;
            if (e.cyc < cyc) begin
                n_fail++;
                $display("FAIL %s: expectation stale at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
            end else if ({clk_en, gated, wake_ack} !== {e.en, e.g, e.ack}) begin
                n_fail++;
                $display("FAIL %s: cyc %0d en/gated/ack got %b%b%b expected %b%b%b",
                         e.name, cyc, clk_en, gated, wake_ack, e.en, e.g, e.ack);
            end
`ifdef NOC_CLK_GATE_STATS_EN
            if (e.st) begin
                n_tests++;
                if (gated_cycles !== e.gc || gate_events !== e.ge) begin
                    n_fail++;
                    $display("FAIL %s_stats: cycles/events got %0d/%0d expected %0d/%0d",
                             e.name, gated_cycles, gate_events, e.gc, e.ge);
                end
            end
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input logic en, input logic g, input logic ack, input string name);
        exp_t e;
        e.cyc = cyc; e.en = en; e.g = g; e.ack = ack;
        e.st = 1'b0; e.gc = '0; e.ge = '0; e.name = name;
        sb.push_back(e);
    endtask

    task automatic chk_st(input logic en, input logic g, input logic ack,
                          input logic [31:0] gc, input logic [15:0] ge, input string name);
        exp_t e;
        e.cyc = cyc; e.en = en; e.g = g; e.ack = ack;
        e.st = 1'b1; e.gc = gc; e.ge = ge; e.name = name;
        sb.push_back(e);
    endtask

    // Three idle cycles still enabled, gated on the fourth (thresh=4).
    task automatic expect_gate4(input string name);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk(1'b1, 1'b0, 1'b0, name);
        end
        tick();
        chk(1'b0, 1'b1, 1'b0, name);
    endtask

    // One gated period of exactly len cycles, ended by a one-cycle busy pulse.
    task automatic gate_period(input int len);
        int waited;
        waited = 0;
        while (gated !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        if (gated !== 1'b1) begin
            n_fail++;
            $display("FAIL gate_wait: o_gated=%b after 50 cycles, required 1", gated);
        end
        repeat (len - 1) tick();
        busy = 1'b1;
        tick();
        busy = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        thresh   = 8'd4;
        force_on = 1'b0;
        busy     = 1'b0;
        wake_req = 1'b0;

        // Reset and first gating
        tick(); tick();
        chk(1'b1, 1'b0, 1'b0, "rst_hold");
        rst_n = 1'b1;
        expect_gate4("gate_after_rst");

        // Wake handshake
        tick(); wake_req = 1'b1; chk(1'b0, 1'b1, 1'b0, "gated_req");
        tick(); chk(1'b1, 1'b0, 1'b0, "wake_en");
        tick(); chk(1'b1, 1'b0, 1'b0, "wake_no_ack");
        tick(); chk(1'b1, 1'b0, 1'b1, "wake_ack");
        tick(); wake_req = 1'b0; chk(1'b1, 1'b0, 1'b0, "ack_drop");

        // Busy on the 4th idle cycle cancels gating
        tick(); chk(1'b1, 1'b0, 1'b0, "idle2");
        tick(); chk(1'b1, 1'b0, 1'b0, "idle3");
        tick(); busy = 1'b1; chk(1'b1, 1'b0, 1'b0, "busy_4th");
        tick(); busy = 1'b0; chk(1'b1, 1'b0, 1'b0, "busy_cancel");
        expect_gate4("regate_after_busy");

        // Force-on wakes in one cycle and holds
        tick(); force_on = 1'b1; chk(1'b0, 1'b1, 1'b0, "gated_force");
        tick(); chk(1'b1, 1'b0, 1'b0, "force_wake");
        for (int i = 0; i < 1000; i++) begin
            tick(); chk(1'b1, 1'b0, 1'b0, "force_hold");
        end
        tick(); force_on = 1'b0; thresh = 8'd0; chk(1'b1, 1'b0, 1'b0, "thr0_start");
        for (int i = 0; i < 1000; i++) begin
            tick(); chk(1'b1, 1'b0, 1'b0, "thr0_hold");
        end
        tick(); thresh = 8'd4; chk(1'b1, 1'b0, 1'b0, "thr4_start");
        expect_gate4("thr4_gate");

        // Threshold 0 while gated wakes; lowering threshold mid-count gates next idle cycle
        tick(); thresh = 8'd0; chk(1'b0, 1'b1, 1'b0, "gated_thr0");
        tick(); chk(1'b1, 1'b0, 1'b0, "thr0_wake");
        tick(); chk(1'b1, 1'b0, 1'b0, "thr0_wake2");
        tick(); thresh = 8'd10; chk(1'b1, 1'b0, 1'b0, "thr10_run");
        tick(); chk(1'b1, 1'b0, 1'b0, "thr10_idle1");
        tick(); chk(1'b1, 1'b0, 1'b0, "thr10_idle2");
        tick(); thresh = 8'd2; chk(1'b1, 1'b0, 1'b0, "thr_lower");
        tick(); chk(1'b0, 1'b1, 1'b0, "thr_lower_gate");

        // Asynchronous reset while gated
        tick(); rst_n = 1'b0; thresh = 8'd4; chk(1'b1, 1'b0, 1'b0, "arst_gated");
        tick(); rst_n = 1'b1; chk(1'b1, 1'b0, 1'b0, "arst_release");
        expect_gate4("arst_regate");

        // Asynchronous reset while waking
        tick(); wake_req = 1'b1; chk(1'b0, 1'b1, 1'b0, "wake_req2");
        tick(); chk(1'b1, 1'b0, 1'b0, "wake_pre_rst");
        tick(); rst_n = 1'b0; wake_req = 1'b0; chk(1'b1, 1'b0, 1'b0, "arst_wake");
        tick(); rst_n = 1'b1; chk(1'b1, 1'b0, 1'b0, "arst_wake_rel");
        expect_gate4("arst_wake_regate");

        // Statistics: gate periods of 20, 5 and 7 cycles
        tick(); rst_n = 1'b0;
        tick(); rst_n = 1'b1;
        gate_period(20);
        gate_period(5);
        gate_period(7);
        tick();
`ifdef NOC_CLK_GATE_STATS_EN
        chk_st(1'b1, 1'b0, 1'b0, 32'd32, 16'd3, "stats");
`else
        chk(1'b1, 1'b0, 1'b0, "stats_run");
`endif

        repeat (3) tick();
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
